// File: rtl/mult_err_pkg.sv
// rtl/mult_err_pkg.sv - shared types and helpers for the multiplier error monitor
package mult_err_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int HIST_BINS  = 16;
    // Widest error distance the bit-scan helper accepts (WIDTH+1 must fit).
    localparam int MSB_SCAN_W = 128;

    // Index of the highest set bit; 0 for a zero input.
    function automatic logic [6:0] msb_index(input logic [MSB_SCAN_W-1:0] v);
        logic [6:0] idx;
        idx = '0;
        for (int i = 0; i < MSB_SCAN_W; i++) begin
            if (v[i]) idx = 7'(i);
        end
        return idx;
    endfunction

    // Histogram bin: four MSB positions per bin, indices past 63 fold into the top bin.
    function automatic logic [3:0] hist_bin(input logic [MSB_SCAN_W-1:0] v);
        logic [6:0] idx;
        idx = msb_index(v);
        return idx[6] ? 4'hF : idx[5:2];
    endfunction

endpackage

// File: rtl/mult_err_absdiff.sv
// rtl/mult_err_absdiff.sv - two-stage signed difference / absolute value pipeline
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid        operand pair valid (already qualified by acceptance)
//   a, b            signed operands, WIDTH bits
//   s1_valid        stage 1 holds a difference
//   s2_valid        stage 2 holds an error distance
//   ed              |a - b|, WIDTH+1 bits unsigned
//   ne              a != b
module mult_err_absdiff #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             s1_valid,
    output logic             s2_valid,
    output logic [WIDTH:0]   ed,
    output logic             ne
);

    logic [WIDTH:0] d;

    // One extra bit makes the difference exact for every operand pair, and
    // its magnitude never reaches 2^WIDTH, so the negation cannot overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            d        <= '0;
            ed       <= '0;
            ne       <= 1'b0;
        end else begin
            s1_valid <= in_valid;
            s2_valid <= s1_valid;
            if (in_valid) begin
                d <= {a[WIDTH-1], a} - {b[WIDTH-1], b};
            end
            if (s1_valid) begin
                ed <= d[WIDTH] ? -d : d;
                ne <= |d;
            end
        end
    end

endmodule

// File: rtl/mult_err_monitor.sv
// rtl/mult_err_monitor.sv - error statistics monitor for approximate/exact product pairs
//
// Optional feature: define MULT_ERR_HIST_EN to add the 16-bin ED histogram
// and the hist_flat output port.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a run (honoured in IDLE or DONE only)
//   in_valid        y_appx / y_exact valid this cycle
//   y_appx, y_exact signed products, WIDTH bits
//   busy            run in progress (RUN or DRAIN), registered
//   done            results stable, registered
//   sample_count    pairs accepted this run
//   err_count       pairs with y_appx != y_exact
//   max_ed          largest |y_appx - y_exact|
//   sum_ed          saturating sum of error distances
//   sum_sat         sticky sum saturation flag
//   hist_flat       (MULT_ERR_HIST_EN) 16 bins of CNT_W, bin k at [k*CNT_W +: CNT_W]
module mult_err_monitor
    import mult_err_pkg::*;
#(
    parameter int WIDTH     = 64,
    parameter int N_SAMPLES = 1024,
    parameter int CNT_W     = 32,
    parameter int SUM_W     = 80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] y_appx,
    input  logic [WIDTH-1:0] y_exact,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_count,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH:0]   max_ed,
    output logic [SUM_W-1:0] sum_ed,
    output logic             sum_sat
`ifdef MULT_ERR_HIST_EN
    ,
    output logic [HIST_BINS*CNT_W-1:0] hist_flat
`endif
);

    state_t state, next_state;
    logic   busy_d, done_d;
    logic   accept, start_ok, pipe_empty, run_full;

    logic           s1_valid, s2_valid, ne;
    logic [WIDTH:0] ed;
    logic [SUM_W:0] sum_next;

    assign run_full   = (sample_count == CNT_W'(N_SAMPLES));
    assign accept     = (state == RUN) && in_valid && (sample_count < CNT_W'(N_SAMPLES));
    assign start_ok   = start && ((state == IDLE) || (state == DONE));
    assign pipe_empty = !s1_valid && !s2_valid;

    mult_err_absdiff #(.WIDTH(WIDTH)) u_absdiff (
        .clk      (clk),
        .rst      (rst),
        .in_valid (accept),
        .a        (y_appx),
        .b        (y_exact),
        .s1_valid (s1_valid),
        .s2_valid (s2_valid),
        .ed       (ed),
        .ne       (ne)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= busy_d;
            done  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start)      next_state = RUN;
            RUN:     if (run_full)   next_state = DRAIN;
            DRAIN:   if (pipe_empty) next_state = DONE;
            DONE:    if (start)      next_state = RUN;
            default:                 next_state = IDLE;
        endcase
    end

    // Outputs decoded from the next state so the registered flags track the state register.
    always_comb begin
        busy_d = (next_state == RUN) || (next_state == DRAIN);
        done_d = (next_state == DONE);
    end

    // Extra carry bit detects wrap of the accumulator.
    assign sum_next = {1'b0, sum_ed} + (SUM_W+1)'(ed);

    // The pipeline is empty whenever start is honoured, so clear and update never collide.
    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            sample_count <= '0;
            err_count    <= '0;
            max_ed       <= '0;
            sum_ed       <= '0;
            sum_sat      <= 1'b0;
        end else begin
            if (accept) begin
                sample_count <= sample_count + CNT_W'(1);
            end
            if (s2_valid) begin
                err_count <= err_count + CNT_W'(ne);
                if (ed > max_ed) begin
                    max_ed <= ed;
                end
                if (sum_next[SUM_W]) begin
                    sum_ed  <= '1;
                    sum_sat <= 1'b1;
                end else begin
                    sum_ed <= sum_next[SUM_W-1:0];
                end
            end
        end
    end

`ifdef MULT_ERR_HIST_EN
    logic [CNT_W-1:0] hist [HIST_BINS];
    logic [3:0]       bin_sel;

    assign bin_sel = hist_bin(MSB_SCAN_W'(ed));

    always_ff @(posedge clk) begin
        if (rst || start_ok) begin
            for (int k = 0; k < HIST_BINS; k++) begin
                hist[k] <= '0;
            end
        end else if (s2_valid && (hist[bin_sel] != '1)) begin
            hist[bin_sel] <= hist[bin_sel] + CNT_W'(1);
        end
    end

    for (genvar g = 0; g < HIST_BINS; g++) begin : g_hist_flat
        assign hist_flat[g*CNT_W +: CNT_W] = hist[g];
    end
`endif

endmodule

// File: tb/tb_mult_err_monitor.sv
// tb/tb_mult_err_monitor.sv - directed self-checking bench for mult_err_monitor
module tb_mult_err_monitor;

    localparam int WIDTH = 64;
    localparam int N     = 4;
    localparam int CNT_W = 32;
    localparam int SUM_W = 65;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] y_appx;
    logic [WIDTH-1:0] y_exact;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] sample_count;
    logic [CNT_W-1:0] err_count;
    logic [WIDTH:0]   max_ed;
    logic [SUM_W-1:0] sum_ed;
    logic             sum_sat;
`ifdef MULT_ERR_HIST_EN
    logic [16*CNT_W-1:0] hist_flat;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mult_err_monitor #(
        .WIDTH(WIDTH), .N_SAMPLES(N), .CNT_W(CNT_W), .SUM_W(SUM_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_valid     (in_valid),
        .y_appx       (y_appx),
        .y_exact      (y_exact),
        .busy         (busy),
        .done         (done),
        .sample_count (sample_count),
        .err_count    (err_count),
        .max_ed       (max_ed),
        .sum_ed       (sum_ed),
        .sum_sat      (sum_sat)
`ifdef MULT_ERR_HIST_EN
        ,
        .hist_flat    (hist_flat)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; y_appx = '0; y_exact = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic feed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        in_valid = 1'b1; y_appx = a; y_exact = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 20 && !done; i++) step();
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL wait_done: done=%b required 1 within 20 cycles", done);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (sample_count !== '0) begin failures++; $display("FAIL reset_count: got %0d want 0", sample_count); end
        checks++; if (max_ed !== '0 || sum_ed !== '0 || err_count !== '0 || sum_sat !== 1'b0) begin
            failures++; $display("FAIL reset_stats: err=%0d max=%h sum=%h sat=%b want all 0", err_count, max_ed, sum_ed, sum_sat);
        end
    endtask

    task automatic test_equal();
        pulse_start();
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL eq_busy: got %b want 1", busy); end
        for (int i = 0; i < N; i++) feed(64'h1234, 64'h1234);
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL eq_done_early1: got %b want 0", done); end
        step();
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL eq_done_early2: got %b want 0", done); end
        step();
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL eq_done_lat: done=%b busy=%b want 1/0", done, busy); end
        checks++; if (sample_count !== 32'd4) begin failures++; $display("FAIL eq_count: got %0d want 4", sample_count); end
        checks++; if (err_count !== 32'd0 || max_ed !== '0 || sum_ed !== '0) begin
            failures++; $display("FAIL eq_stats: err=%0d max=%h sum=%h want 0/0/0", err_count, max_ed, sum_ed);
        end
    endtask

    task automatic test_errors();
        pulse_start();
        feed(64'd10, 64'd7);
        feed(-64'sd5, -64'sd5);
        feed(64'd0, -64'sd9);
        feed(64'd100, 64'd90);
        wait_done();
        checks++; if (err_count !== 32'd3) begin failures++; $display("FAIL err_count: got %0d want 3", err_count); end
        checks++; if (max_ed !== 65'd10) begin failures++; $display("FAIL err_max: got %0d want 10", max_ed); end
        checks++; if (sum_ed !== 65'd22) begin failures++; $display("FAIL err_sum: got %0d want 22", sum_ed); end
        checks++; if (sum_sat !== 1'b0) begin failures++; $display("FAIL err_sat: got %b want 0", sum_sat); end
    endtask

    task automatic test_saturation();
        pulse_start();
        for (int i = 0; i < N; i++) feed(64'h7FFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
        wait_done();
        checks++; if (max_ed !== 65'h0_FFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL sat_max: got %h want 0ffffffffffffffff", max_ed); end
        checks++; if (sum_ed !== {SUM_W{1'b1}}) begin failures++; $display("FAIL sat_sum: got %h want all ones", sum_ed); end
        checks++; if (sum_sat !== 1'b1) begin failures++; $display("FAIL sat_flag: got %b want 1", sum_sat); end
        checks++; if (err_count !== 32'd4) begin failures++; $display("FAIL sat_err: got %0d want 4", err_count); end
    endtask

    task automatic test_drop();
        // in_valid while DONE is ignored
        for (int i = 0; i < 3; i++) feed(64'd5, 64'd0);
        checks++; if (sample_count !== 32'd4 || sum_ed !== {SUM_W{1'b1}}) begin
            failures++; $display("FAIL drop_idle: count=%0d sum=%h want 4/all ones", sample_count, sum_ed);
        end
        // start clears stats and the start-cycle sample is not accepted
        start = 1'b1; in_valid = 1'b1; y_appx = 64'd5; y_exact = 64'd0;
        step();
        start = 1'b0;
        checks++; if (sample_count !== '0 || sum_ed !== '0 || sum_sat !== 1'b0) begin
            failures++; $display("FAIL drop_clear: count=%0d sum=%h sat=%b want 0/0/0", sample_count, sum_ed, sum_sat);
        end
        // in_valid held 8 cycles with a start pulse mid-run
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; y_appx = 64'(k + 1); y_exact = 64'd0; start = (k == 2);
            step();
        end
        start = 1'b0; in_valid = 1'b0;
        wait_done();
        checks++; if (sample_count !== 32'd4) begin failures++; $display("FAIL drop_count: got %0d want 4", sample_count); end
        checks++; if (sum_ed !== 65'd10 || max_ed !== 65'd4 || err_count !== 32'd4) begin
            failures++; $display("FAIL drop_stats: sum=%0d max=%0d err=%0d want 10/4/4", sum_ed, max_ed, err_count);
        end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL b2b_restart: busy=%b done=%b want 1/0", busy, done); end
        for (int i = 0; i < N; i++) feed(64'd3, 64'd1);
        wait_done();
        checks++; if (sum_ed !== 65'd8 || max_ed !== 65'd2 || err_count !== 32'd4) begin
            failures++; $display("FAIL b2b_stats: sum=%0d max=%0d err=%0d want 8/2/4", sum_ed, max_ed, err_count);
        end
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        feed(64'd10, 64'd0);
        feed(64'd20, 64'd0);
        rst = 1'b1; start = 1'b1; in_valid = 1'b1; y_appx = 64'd30; y_exact = 64'd0;
        step();
        rst = 1'b0; start = 1'b0; in_valid = 1'b0;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || sample_count !== '0) begin
            failures++; $display("FAIL rst_mid_ctrl: busy=%b done=%b count=%0d want 0/0/0", busy, done, sample_count);
        end
        checks++; if (err_count !== '0 || max_ed !== '0 || sum_ed !== '0 || sum_sat !== 1'b0) begin
            failures++; $display("FAIL rst_mid_stats: err=%0d max=%0d sum=%0d sat=%b want 0", err_count, max_ed, sum_ed, sum_sat);
        end
        for (int i = 0; i < 4; i++) step();
        checks++; if (busy !== 1'b0 || sum_ed !== '0 || err_count !== '0) begin
            failures++; $display("FAIL rst_mid_flush: busy=%b sum=%0d err=%0d want 0/0/0", busy, sum_ed, err_count);
        end
        pulse_start();
        feed(64'd10, 64'd7);
        feed(-64'sd5, -64'sd5);
        feed(64'd0, -64'sd9);
        feed(64'd100, 64'd90);
        wait_done();
        checks++; if (err_count !== 32'd3 || max_ed !== 65'd10 || sum_ed !== 65'd22 || sample_count !== 32'd4) begin
            failures++; $display("FAIL rst_rerun: err=%0d max=%0d sum=%0d count=%0d want 3/10/22/4", err_count, max_ed, sum_ed, sample_count);
        end
    endtask

`ifdef MULT_ERR_HIST_EN
    task automatic test_hist();
        logic [CNT_W-1:0] want;
        pulse_start();
        feed(64'd0, 64'd0);
        feed(64'd1, 64'd0);
        feed(64'd16, 64'd0);
        feed(64'h100_0000_0000, 64'd0);
        wait_done();
        for (int k = 0; k < 16; k++) begin
            want = (k == 0) ? 32'd2 : ((k == 1 || k == 10) ? 32'd1 : 32'd0);
            checks++;
            if (hist_flat[k*CNT_W +: CNT_W] !== want) begin
                failures++; $display("FAIL hist_bin%0d: got %0d want %0d", k, hist_flat[k*CNT_W +: CNT_W], want);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_equal();
        test_errors();
        test_saturation();
        test_drop();
        test_back_to_back();
        test_reset_mid_run();
`ifdef MULT_ERR_HIST_EN
        test_hist();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
